grid_removal_scheduler: RTL



---
 rtl/grid_removal_scheduler_if.sv | 28 ++
 rtl/grid_removal_scheduler.sv | 124 ++++++++++++
 2 files changed

// File: rtl/grid_removal_scheduler_if.sv
// Load/control bus of the grid removal scheduler.
// load_valid/load_ready: a row transfers on a rising clk edge where both are 1; the
// driver holds load_data stable while load_valid is 1, and load_ready never depends on load_valid.
interface grid_removal_scheduler_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(WIDTH * DEPTH + 1)
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             start;
  logic             busy;
  logic             done;
  logic [CW-1:0]    total_removed;
  logic [CW-1:0]    pass_count;
  logic [2:0]       state_dbg;

  modport slave (
    input  load_valid, load_data, start,
    output load_ready, busy, done, total_removed, pass_count, state_dbg
  );

  modport master (
    output load_valid, load_data, start,
    input  load_ready, busy, done, total_removed, pass_count, state_dbg
  );
endinterface

// File: rtl/grid_removal_scheduler.sv
// Loads an occupancy grid row by row, then sweeps it in place one row per cycle,
// removing rolls with fewer than 4 occupied neighbours until a pass removes nothing.
module grid_removal_scheduler #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(WIDTH * DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  grid_removal_scheduler_if.slave bus
);
  localparam int RW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [RW-1:0] LAST = RW'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    LOADED = 3'd2,
    SCAN   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] grid [DEPTH];
  logic [RW-1:0]    r;
  logic [CW-1:0]    pass_removed;
  logic [CW-1:0]    total_removed;
  logic [CW-1:0]    pass_count;

  logic             accept;
  logic             load_ready;
  logic [WIDTH-1:0] row_prev, row_cur, row_next;
  logic [WIDTH+1:0] p_pad, c_pad, n_pad;
  logic [WIDTH-1:0] removable;
  logic [3:0]       nb;
  logic [CW-1:0]    k;
  logic [CW-1:0]    pass_sum;

  // Row r-1 has already been rewritten this pass; rows r and r+1 are still the old contents.
  always_comb begin
    row_prev = '0;
    row_next = '0;
    row_cur  = grid[r];
    if (r != '0) row_prev = grid[r - 1'b1];
    if (r != LAST) row_next = grid[r + 1'b1];
  end

  assign p_pad = {1'b0, row_prev, 1'b0};
  assign c_pad = {1'b0, row_cur, 1'b0};
  assign n_pad = {1'b0, row_next, 1'b0};

  always_comb begin
    removable = '0;
    nb        = '0;
    k         = '0;
    for (int j = 0; j < WIDTH; j++) begin
      nb = 4'(p_pad[j]) + 4'(p_pad[j+1]) + 4'(p_pad[j+2])
         + 4'(c_pad[j])                  + 4'(c_pad[j+2])
         + 4'(n_pad[j]) + 4'(n_pad[j+1]) + 4'(n_pad[j+2]);
      removable[j] = c_pad[j+1] & (nb < 4'd4);
      k = k + CW'(removable[j]);
    end
  end

  assign pass_sum = pass_removed + k;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_ready = (state == IDLE) || (state == LOAD) || (state == DONE);
    accept     = bus.load_valid & load_ready;
    case (state)
      IDLE, LOAD, DONE: if (accept) state_next = (r == LAST) ? LOADED : LOAD;
      LOADED:           if (bus.start) state_next = SCAN;
      SCAN:             if (r == LAST && pass_sum == '0) state_next = DONE;
      default:          state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) grid[i] <= '0;
      r             <= '0;
      pass_removed  <= '0;
      total_removed <= '0;
      pass_count    <= '0;
    end else begin
      if (accept) begin
        grid[r] <= bus.load_data;
        r       <= (r == LAST) ? '0 : r + 1'b1;
        // A fresh load discards the previous run's results on its first row.
        if (state != LOAD) begin
          total_removed <= '0;
          pass_count    <= '0;
        end
      end else if (state == LOADED && bus.start) begin
        r            <= '0;
        pass_removed <= '0;
      end else if (state == SCAN) begin
        grid[r]       <= row_cur & ~removable;
        total_removed <= total_removed + k;
        if (r == LAST) begin
          r            <= '0;
          pass_removed <= '0;
          pass_count   <= pass_count + CW'(1);
        end else begin
          r            <= r + 1'b1;
          pass_removed <= pass_sum;
        end
      end
    end
  end

  assign bus.load_ready    = load_ready;
  assign bus.busy          = (state == SCAN);
  assign bus.done          = (state == DONE);
  assign bus.total_removed = total_removed;
  assign bus.pass_count    = pass_count;
  assign bus.state_dbg     = state;
endmodule
